// File: rtl/ser_transmitter_pkg.sv
// ser_pkg: shared types and constants for the serial framing transmitter.
//   state_t       - FSM state encoding (IDLE, TRANSMIT, PARITY)
//   CNT_W         - width of the payload bit counter / count_out
//   DEF_DATA_BITS - default payload length per frame
package ser_pkg;
    localparam int CNT_W         = 4;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSMIT = 2'd1,
        PARITY   = 2'd2
    } state_t;
endpackage

// File: rtl/ser_transmitter_if.sv
// ser_transmitter_if: serial-side signal bundle of the transmitter.
//   clkEn       - bit-rate strobe
//   serIn       - serial input line (idle high, start bit low)
//   serOut      - forwarded payload (or parity) bit
//   serOutValid - serOut carries a bit this cycle
//   count_out   - index of the bit on serOut
// Modports: master drives clkEn/serIn (pin side / bench), slave is the transmitter.
interface ser_transmitter_if;
    logic                       clkEn;
    logic                       serIn;
    logic                       serOut;
    logic                       serOutValid;
    logic [ser_pkg::CNT_W-1:0]  count_out;

    modport master (output clkEn, serIn, input serOut, serOutValid, count_out);
    modport slave  (input clkEn, serIn, output serOut, serOutValid, count_out);
endinterface

// File: rtl/ser_transmitter_bit_counter.sv
// ser_bit_counter: payload bit index counter.
//   clk, rst - clock, synchronous active-low reset
//   clr      - force counter to zero (start of frame)
//   en       - advance on this edge
//   tc       - terminal count; advancing from tc returns to zero instead of wrapping
//   cnt      - current count
module ser_bit_counter
    import ser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == tc) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/ser_transmitter.sv
// ser_transmitter: waits for a start bit on serIn, then forwards the next
// DATA_BITS bits to serOut with a valid flag and bit index. All advancement
// is gated by the clkEn bit strobe; outputs in TRANSMIT are combinational.
//   clk, rst - clock, synchronous active-low reset
//   sif      - ser_transmitter_if.slave (clkEn, serIn, serOut, serOutValid, count_out)
// Optional: define SER_TRANSMITTER_PARITY_EN to append one even-parity bit
// (count_out = DATA_BITS) after the payload.
module ser_transmitter
    import ser_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic               clk,
    input  logic               rst,
    ser_transmitter_if.slave   sif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_en;
    logic             start;

    // Start bit: low serIn on an enabled IDLE cycle; it is consumed, not forwarded.
    assign start = (state_q == IDLE) && sif.clkEn && !sif.serIn;

    ser_bit_counter u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (LAST),
        .cnt (cnt)
    );

`ifdef SER_TRANSMITTER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rst)
            par_q <= 1'b0;
        else if (start)
            par_q <= 1'b0;
        else if (state_q == TRANSMIT && sif.clkEn)
            par_q <= par_q ^ sif.serIn;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        cnt_clr         = 1'b0;
        cnt_en          = 1'b0;
        sif.serOut      = 1'b0;
        sif.serOutValid = 1'b0;
        sif.count_out   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRANSMIT;
                    cnt_clr = 1'b1;
                end
            end
            TRANSMIT: begin
                sif.serOut      = sif.serIn;
                sif.serOutValid = sif.clkEn;
                sif.count_out   = cnt;
                // Counter self-clears when advancing past LAST.
                cnt_en          = sif.clkEn;
                if (sif.clkEn && cnt == LAST) begin
`ifdef SER_TRANSMITTER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SER_TRANSMITTER_PARITY_EN
            PARITY: begin
                sif.serOut      = par_q;
                sif.serOutValid = sif.clkEn;
                sif.count_out   = CNT_W'(DATA_BITS);
                if (sif.clkEn)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ser_transmitter.sv
// Directed bench for ser_transmitter: each driven cycle pushes its expected
// outputs to a scoreboard; a negedge process pops and checks them.
module tb_ser_transmitter;
    import ser_pkg::*;

    localparam int DB = 8;

    typedef struct {
        logic       v;
        logic       o;
        logic [3:0] c;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ser_transmitter_if sif();

    ser_transmitter #(.DATA_BITS(DB)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Drive one cycle's inputs and record what the outputs must be during it.
    task automatic cyc(input logic r, input logic en, input logic si,
                       input logic ev, input logic eo, input logic [3:0] ec,
                       input string tag);
        exp_t e;
        rst       = r;
        sif.clkEn = en;
        sif.serIn = si;
        e.v = ev; e.o = eo; e.c = ec; e.tag = tag;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    // Start bit, DATA_BITS payload bits (optional 2-cycle pause before bit
    // pause_at), parity bit when enabled, optional trailing idle cycle.
    task automatic frame(input logic [7:0] bits, input int pause_at,
                         input bit trail, input string tag);
        cyc(1, 1, 0, 0, 0, 4'd0, {tag, "_start"});
        for (int i = 0; i < DB; i++) begin
            if (i == pause_at)
                repeat (2) cyc(1, 0, 1, 0, 1, 4'(i), {tag, "_pause"});
            cyc(1, 1, bits[i], 1, bits[i], 4'(i), $sformatf("%s_b%0d", tag, i));
        end
`ifdef SER_TRANSMITTER_PARITY_EN
        cyc(1, 1, 1, 1, ^bits, 4'(DB), {tag, "_par"});
`endif
        if (trail)
            cyc(1, 1, 1, 0, 0, 4'd0, {tag, "_idle"});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp += 3;
            assert (sif.serOutValid === e.v) else begin
                n_err++;
                $error("FAIL %s serOutValid got %b exp %b", e.tag, sif.serOutValid, e.v);
            end
            assert (sif.serOut === e.o) else begin
                n_err++;
                $error("FAIL %s serOut got %b exp %b", e.tag, sif.serOut, e.o);
            end
            assert (sif.count_out === e.c) else begin
                n_err++;
                $error("FAIL %s count_out got %0d exp %0d", e.tag, sif.count_out, e.c);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        sif.clkEn = 1'b1;
        sif.serIn = 1'b1;
        @(posedge clk); #1;

        // Reset held with serIn toggling, then released with line idle.
        cyc(0, 1, 0, 0, 0, 4'd0, "rst0");
        cyc(0, 1, 1, 0, 0, 4'd0, "rst1");
        cyc(1, 1, 1, 0, 0, 4'd0, "rel0");
        cyc(1, 1, 1, 0, 0, 4'd0, "rel1");

        // Payload 1,0,1,1,0,0,1,0 (bit0 first).
        frame(8'h4D, -1, 1, "basic");

        // Pause of two disabled cycles at index 3.
        frame(8'hB2, 3, 1, "pause");

        // Start bit ignored while clkEn is low.
        cyc(1, 0, 0, 0, 0, 4'd0, "gate0");
        cyc(1, 0, 0, 0, 0, 4'd0, "gate1");
        frame(8'h5A, -1, 1, "gated");

        // Back-to-back frames: start bit on the first enabled IDLE cycle.
        frame(8'hC3, -1, 0, "b2b_a");
        frame(8'h3C, -1, 1, "b2b_b");

        // Reset asserted while index 5 is on the wire.
        cyc(1, 1, 0, 0, 0, 4'd0, "mid_start");
        for (int i = 0; i < 5; i++)
            cyc(1, 1, i[0], 1, i[0], 4'(i), $sformatf("mid_b%0d", i));
        cyc(0, 1, 1, 1, 1, 4'd5, "mid_rst");
        cyc(1, 1, 1, 0, 0, 4'd0, "mid_idle");
        frame(8'h96, -1, 1, "fresh");

        // Payload 1,1,0,1,0,0,0,0 (odd count of ones).
        frame(8'h0B, -1, 1, "par_pat");

        repeat (4) if (sb.size() != 0) @(posedge clk);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain pending got %0d exp 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
